// File: rtl/seg_display_feeder_if.sv
// ---------------------------------------------------------------------------
// seg_display_feeder_if
// Valid/ready write port of the seven-segment display feeder.
//   wr_valid  master -> slave  write request
//   wr_ready  slave -> master  write can be accepted this cycle
//   wr_data   master -> slave  32-bit display value, nibble i = digit i
//   wr_mask   master -> slave  byte enables, bit b covers wr_data[8b+7:8b]
// ---------------------------------------------------------------------------
interface seg_display_feeder_if;
    logic        wr_valid;
    logic        wr_ready;
    logic [31:0] wr_data;
    logic [3:0]  wr_mask;

    modport master (
        output wr_valid,
        output wr_data,
        output wr_mask,
        input  wr_ready
    );

    modport slave (
        input  wr_valid,
        input  wr_data,
        input  wr_mask,
        output wr_ready
    );
endinterface

// File: rtl/seg_display_feeder.sv
// ---------------------------------------------------------------------------
// seg_display_feeder
// Upstream feeder for the 8-digit hex seven-segment display path. Captures
// display values from a byte-masked valid/ready write port, enforces a
// minimum hold time between accepted writes, and drives the display value
// plus per-digit enables (static enable mask, leading-zero blanking, blink).
//
// Ports
//   clk           rising-edge system clock
//   rst           asynchronous, active-low reset
//   wr_if         slave side of the valid/ready write port
//   cfg_lz_blank  1 = blank digits above the highest nonzero nibble
//   cfg_blink     1 = blink the whole display
//   cfg_digit_en  static per-digit enable mask
//   output_data   registered display value
//   output_valid  registered per-digit enables, aligned with output_data
// ---------------------------------------------------------------------------
module seg_display_feeder #(
    parameter int unsigned      HOLD_CYCLES = 4,
    parameter int unsigned      BLINK_HALF  = 25_000_000,
    parameter logic [31:0]      RESET_VALUE = 32'h0000_0000
) (
    input  logic                 clk,
    input  logic                 rst,
    seg_display_feeder_if.slave  wr_if,
    input  logic                 cfg_lz_blank,
    input  logic                 cfg_blink,
    input  logic [7:0]           cfg_digit_en,
    output logic [31:0]          output_data,
    output logic [7:0]           output_valid
);

    localparam int HW = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;
    localparam int BW = (BLINK_HALF  > 1) ? $clog2(BLINK_HALF)  : 1;
    localparam logic [HW-1:0] HOLD_LOAD  = HW'(HOLD_CYCLES - 1);
    localparam logic [BW-1:0] BLINK_LAST = BW'(BLINK_HALF - 1);

    typedef enum logic [1:0] {
        ST_INIT,
        ST_IDLE,
        ST_HOLD
    } state_t;

    state_t        r_state;
    state_t        w_state_next;
    logic [HW-1:0] r_hold_cnt;
    logic [HW-1:0] w_hold_cnt_next;
    logic [BW-1:0] r_blink_cnt;
    logic [BW-1:0] w_blink_cnt_next;
    logic          r_blink_on;
    logic          w_blink_on_next;
    logic          r_wr_ready;
    logic          w_wr_ready_next;
    logic [31:0]   r_data;
    logic [31:0]   w_data_next;
    logic [7:0]    r_valid;
    logic [7:0]    w_valid_next;

    logic          w_accept;
    logic [7:0]    w_nz;
    logic [7:0]    w_keep;

    // r_wr_ready is only ever high in IDLE, so it alone qualifies an accept.
    assign w_accept = wr_if.wr_valid && r_wr_ready;

    // Byte-masked update of the display value on the accept edge.
    for (genvar gi = 0; gi < 4; gi++) begin : g_byte
        assign w_data_next[8*gi +: 8] = (w_accept && wr_if.wr_mask[gi])
                                        ? wr_if.wr_data[8*gi +: 8]
                                        : r_data[8*gi +: 8];
    end

    // Leading-zero blanking works on the value being registered this edge,
    // so data and its enables appear together. A digit survives if it or any
    // higher digit is nonzero; digit 0 always survives so zero shows as "0".
    for (genvar gi = 0; gi < 8; gi++) begin : g_digit
        assign w_nz[gi] = |w_data_next[4*gi +: 4];
        if (gi == 0) begin : g_lsd
            assign w_keep[gi] = 1'b1;
        end else begin : g_upper
            assign w_keep[gi] = |w_nz[7:gi];
        end
    end

    always_comb begin
        w_state_next     = r_state;
        w_hold_cnt_next  = r_hold_cnt;
        w_wr_ready_next  = r_wr_ready;
        w_blink_cnt_next = r_blink_cnt;
        w_blink_on_next  = r_blink_on;
        w_valid_next     = cfg_digit_en;

        case (r_state)
            ST_INIT: begin
                w_state_next    = ST_IDLE;
                w_wr_ready_next = 1'b1;
            end
            ST_IDLE: begin
                if (w_accept) begin
                    w_state_next    = ST_HOLD;
                    w_wr_ready_next = 1'b0;
                    w_hold_cnt_next = HOLD_LOAD;
                end
            end
            ST_HOLD: begin
                // Counter loaded with HOLD_CYCLES-1 and exits when it reads 0,
                // giving exactly HOLD_CYCLES cycles of wr_ready low.
                if (r_hold_cnt == '0) begin
                    w_state_next    = ST_IDLE;
                    w_wr_ready_next = 1'b1;
                end else begin
                    w_hold_cnt_next = r_hold_cnt - 1'b1;
                end
            end
            default: begin
                w_state_next    = ST_INIT;
                w_wr_ready_next = 1'b0;
            end
        endcase

        if (!cfg_blink) begin
            w_blink_cnt_next = '0;
            w_blink_on_next  = 1'b1;
        end else if (r_blink_cnt == BLINK_LAST) begin
            w_blink_cnt_next = '0;
            w_blink_on_next  = ~r_blink_on;
        end else begin
            w_blink_cnt_next = r_blink_cnt + 1'b1;
        end

        if (cfg_lz_blank) begin
            w_valid_next = cfg_digit_en & w_keep;
        end
        // Uses the phase in effect at this edge; the toggle lands next cycle.
        if (cfg_blink && !r_blink_on) begin
            w_valid_next = 8'h00;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state     <= ST_INIT;
            r_hold_cnt  <= '0;
            r_blink_cnt <= '0;
            r_blink_on  <= 1'b1;
            r_wr_ready  <= 1'b0;
            r_data      <= RESET_VALUE;
            r_valid     <= 8'h00;
        end else begin
            r_state     <= w_state_next;
            r_hold_cnt  <= w_hold_cnt_next;
            r_blink_cnt <= w_blink_cnt_next;
            r_blink_on  <= w_blink_on_next;
            r_wr_ready  <= w_wr_ready_next;
            r_data      <= w_data_next;
            r_valid     <= w_valid_next;
        end
    end

    assign wr_if.wr_ready = r_wr_ready;
    assign output_data    = r_data;
    assign output_valid   = r_valid;

endmodule

// File: tb/tb_seg_display_feeder.sv
module tb_seg_display_feeder;

    logic        clk;
    logic        rst;
    logic        cfg_lz_blank;
    logic        cfg_blink;
    logic [7:0]  cfg_digit_en;
    logic [31:0] output_data;
    logic [7:0]  output_valid;

    int n_cmp;
    int n_bad;

    seg_display_feeder_if wr_if ();

    seg_display_feeder #(
        .HOLD_CYCLES (4),
        .BLINK_HALF  (3),
        .RESET_VALUE (32'h0000_0000)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .wr_if        (wr_if.slave),
        .cfg_lz_blank (cfg_lz_blank),
        .cfg_blink    (cfg_blink),
        .cfg_digit_en (cfg_digit_en),
        .output_data  (output_data),
        .output_valid (output_valid)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Advance to 1 time unit past the next rising edge: sample and drive there.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_ready(input string name);
        int k;
        k = 0;
        while (wr_if.wr_ready !== 1'b1 && k < 20) begin
            tick();
            k++;
        end
        n_cmp++;
        if (wr_if.wr_ready !== 1'b1) begin
            n_bad++;
            $display("FAIL %s: wr_ready timeout, got %b want 1", name, wr_if.wr_ready);
        end
    endtask

    task automatic test_reset();
        rst = 1'b0;
        wr_if.wr_valid = 1'b0;
        wr_if.wr_data  = 32'h0;
        wr_if.wr_mask  = 4'h0;
        cfg_lz_blank = 1'b0;
        cfg_blink    = 1'b0;
        cfg_digit_en = 8'hFF;
        #2;
        tick();
        tick();
        n_cmp++; if (output_data !== 32'h0) begin n_bad++; $display("FAIL reset_data: got %h want 00000000", output_data); end
        n_cmp++; if (output_valid !== 8'h00) begin n_bad++; $display("FAIL reset_valid: got %h want 00", output_valid); end
        n_cmp++; if (wr_if.wr_ready !== 1'b0) begin n_bad++; $display("FAIL reset_ready: got %b want 0", wr_if.wr_ready); end
        $display("reset held: data=%h valid=%h ready=%b", output_data, output_valid, wr_if.wr_ready);
        rst = 1'b1;
        tick();
        n_cmp++; if (wr_if.wr_ready !== 1'b1) begin n_bad++; $display("FAIL release_ready: got %b want 1", wr_if.wr_ready); end
        n_cmp++; if (output_valid !== 8'hFF) begin n_bad++; $display("FAIL release_valid: got %h want FF", output_valid); end
        $display("reset released: valid=%h ready=%b", output_valid, wr_if.wr_ready);
    endtask

    task automatic test_write_hold();
        wr_if.wr_valid = 1'b1;
        wr_if.wr_data  = 32'h1234ABCD;
        wr_if.wr_mask  = 4'hF;
        tick();
        n_cmp++; if (output_data !== 32'h1234ABCD) begin n_bad++; $display("FAIL accept_data: got %h want 1234ABCD", output_data); end
        n_cmp++; if (wr_if.wr_ready !== 1'b0) begin n_bad++; $display("FAIL accept_ready: got %b want 0", wr_if.wr_ready); end
        n_cmp++; if (output_valid !== 8'hFF) begin n_bad++; $display("FAIL accept_valid: got %h want FF", output_valid); end
        $display("write 1234ABCD mask F: data=%h ready=%b", output_data, wr_if.wr_ready);
        // Second write offered immediately and held; must be ignored during HOLD.
        wr_if.wr_data = 32'h0000EE00;
        wr_if.wr_mask = 4'b0010;
        for (int k = 1; k <= 3; k++) begin
            tick();
            n_cmp++; if (wr_if.wr_ready !== 1'b0) begin n_bad++; $display("FAIL hold_ready_%0d: got %b want 0", k, wr_if.wr_ready); end
            n_cmp++; if (output_data !== 32'h1234ABCD) begin n_bad++; $display("FAIL hold_data_%0d: got %h want 1234ABCD", k, output_data); end
        end
        tick();
        n_cmp++; if (wr_if.wr_ready !== 1'b1) begin n_bad++; $display("FAIL hold_exit_ready: got %b want 1", wr_if.wr_ready); end
        n_cmp++; if (output_data !== 32'h1234ABCD) begin n_bad++; $display("FAIL hold_exit_data: got %h want 1234ABCD", output_data); end
        tick();
        wr_if.wr_valid = 1'b0;
        n_cmp++; if (output_data !== 32'h1234EECD) begin n_bad++; $display("FAIL masked_data: got %h want 1234EECD", output_data); end
        n_cmp++; if (wr_if.wr_ready !== 1'b0) begin n_bad++; $display("FAIL second_accept_ready: got %b want 0", wr_if.wr_ready); end
        $display("write 0000EE00 mask 2 after 5 cycles: data=%h ready=%b", output_data, wr_if.wr_ready);
    endtask

    task automatic test_mask_zero();
        wait_ready("mask0_pre");
        wr_if.wr_valid = 1'b1;
        wr_if.wr_data  = 32'hFFFFFFFF;
        wr_if.wr_mask  = 4'h0;
        tick();
        wr_if.wr_valid = 1'b0;
        n_cmp++; if (output_data !== 32'h1234EECD) begin n_bad++; $display("FAIL mask0_data: got %h want 1234EECD", output_data); end
        n_cmp++; if (wr_if.wr_ready !== 1'b0) begin n_bad++; $display("FAIL mask0_ready: got %b want 0", wr_if.wr_ready); end
        $display("write FFFFFFFF mask 0: data=%h ready=%b", output_data, wr_if.wr_ready);
    endtask

    task automatic test_lz_blank();
        cfg_lz_blank = 1'b1;
        cfg_digit_en = 8'hFF;
        wait_ready("lz_pre1");
        wr_if.wr_valid = 1'b1;
        wr_if.wr_data  = 32'h00000A05;
        wr_if.wr_mask  = 4'hF;
        tick();
        wr_if.wr_valid = 1'b0;
        n_cmp++; if (output_data !== 32'h00000A05) begin n_bad++; $display("FAIL lz_a05_data: got %h want 00000A05", output_data); end
        n_cmp++; if (output_valid !== 8'h07) begin n_bad++; $display("FAIL lz_a05_valid: got %h want 07", output_valid); end
        $display("lz=1 data=%h valid=%h", output_data, output_valid);
        wait_ready("lz_pre2");
        wr_if.wr_valid = 1'b1;
        wr_if.wr_data  = 32'h0;
        tick();
        wr_if.wr_valid = 1'b0;
        n_cmp++; if (output_valid !== 8'h01) begin n_bad++; $display("FAIL lz_zero_valid: got %h want 01", output_valid); end
        $display("lz=1 data=%h valid=%h", output_data, output_valid);
        cfg_digit_en = 8'hF0;
        tick();
        n_cmp++; if (output_valid !== 8'h00) begin n_bad++; $display("FAIL lz_enF0_valid: got %h want 00", output_valid); end
        $display("lz=1 en=F0 data=%h valid=%h", output_data, output_valid);
        cfg_lz_blank = 1'b0;
        tick();
        n_cmp++; if (output_valid !== 8'hF0) begin n_bad++; $display("FAIL lz_off_valid: got %h want F0", output_valid); end
        $display("lz=0 en=F0 valid=%h", output_valid);
    endtask

    task automatic test_blink();
        logic [7:0] exp_pat [9];
        exp_pat = '{8'hFF, 8'hFF, 8'hFF, 8'h00, 8'h00, 8'h00, 8'hFF, 8'hFF, 8'hFF};
        cfg_digit_en = 8'hFF;
        cfg_lz_blank = 1'b0;
        cfg_blink    = 1'b0;
        tick();
        cfg_blink = 1'b1;
        for (int k = 0; k < 9; k++) begin
            tick();
            n_cmp++;
            if (output_valid !== exp_pat[k]) begin
                n_bad++;
                $display("FAIL blink_%0d: got %h want %h", k, output_valid, exp_pat[k]);
            end
            $display("blink cycle %0d valid=%h", k, output_valid);
        end
        tick();
        n_cmp++; if (output_valid !== 8'h00) begin n_bad++; $display("FAIL blink_off_again: got %h want 00", output_valid); end
        cfg_blink = 1'b0;
        tick();
        n_cmp++; if (output_valid !== 8'hFF) begin n_bad++; $display("FAIL blink_drop: got %h want FF", output_valid); end
        $display("blink dropped during OFF: valid=%h", output_valid);
    endtask

    task automatic test_reset_mid_hold();
        wait_ready("rst_pre");
        wr_if.wr_valid = 1'b1;
        wr_if.wr_data  = 32'hDEADBEEF;
        wr_if.wr_mask  = 4'hF;
        tick();
        wr_if.wr_valid = 1'b0;
        n_cmp++; if (output_data !== 32'hDEADBEEF) begin n_bad++; $display("FAIL rst_pre_data: got %h want DEADBEEF", output_data); end
        tick();
        #2;
        rst = 1'b0;
        #1;
        n_cmp++; if (output_data !== 32'h0) begin n_bad++; $display("FAIL rst_mid_data: got %h want 00000000", output_data); end
        n_cmp++; if (wr_if.wr_ready !== 1'b0) begin n_bad++; $display("FAIL rst_mid_ready: got %b want 0", wr_if.wr_ready); end
        n_cmp++; if (output_valid !== 8'h00) begin n_bad++; $display("FAIL rst_mid_valid: got %h want 00", output_valid); end
        $display("reset mid-hold: data=%h ready=%b", output_data, wr_if.wr_ready);
        tick();
        rst = 1'b1;
        tick();
        n_cmp++; if (wr_if.wr_ready !== 1'b1) begin n_bad++; $display("FAIL rst_rel_ready: got %b want 1", wr_if.wr_ready); end
        wr_if.wr_valid = 1'b1;
        wr_if.wr_data  = 32'h55AA55AA;
        tick();
        wr_if.wr_valid = 1'b0;
        n_cmp++; if (output_data !== 32'h55AA55AA) begin n_bad++; $display("FAIL rst_rel_accept: got %h want 55AA55AA", output_data); end
        $display("write after reset release: data=%h ready=%b", output_data, wr_if.wr_ready);
    endtask

    initial begin
        n_cmp = 0;
        n_bad = 0;
        test_reset();
        test_write_hold();
        test_mask_zero();
        test_lz_blank();
        test_blink();
        test_reset_mid_hold();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
